mem_port_arbiter: RTL

- Shares one single-ported unified instruction/data memory bus between the fetch stage (F) and the memory stage (M) of the 5-stage pipeline.
- Issues at most one bus transaction at a time. Data accesses win over fetches, because the M-stage instruction is older.
- Holds completed results in buffers and raises mem_stall until every access the current pipeline cycle needs has completed.
- mem_stall is ORed by the top level into StallF/StallD and into new enable inputs on the E/M/W pipeline registers. It freezes the whole pipeline.

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter_if.sv | 25 ++
 rtl/mem_port_arbiter_timer.sv | 26 ++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline constants for the unified memory port.
// Holds the data width and the bus arbiter state encoding.
package rv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } arbState_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-ported memory bus shared by fetch and memory stages.
// master = arbiter side, slave = memory side.
interface mem_port_arbiter_if;
    import rv_pkg::*;

    logic            bus_valid;
    logic            bus_we;
    logic [3:0]      bus_be;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_ready;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_err;

    modport master (
        output bus_valid, bus_we, bus_be, bus_addr, bus_wdata, bus_err,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_be, bus_addr, bus_wdata, bus_err,
        output bus_ready, bus_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_timer.sv
// Wait-state counter for one outstanding bus transaction.
// expired flags that the bus has stalled for LIMIT cycles.
module mem_req_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    // Count wait cycles; clear whenever no transaction is waiting.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified I/D memory bus between fetch and memory stages.
// Data beats fetch; the pipeline is frozen until all needed accesses finish.
module mem_port_arbiter
    import rv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [XLEN-1:0]   PCF,
    output logic [XLEN-1:0]   InstrF,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_be,
    input  logic [XLEN-1:0]   dm_addr,
    input  logic [XLEN-1:0]   dm_wdata,
    output logic [XLEN-1:0]   dm_rdata,
    output logic              mem_stall,
    mem_port_arbiter_if.master bus
);

    arbState_t       state;
    logic            dDone;
    logic            iDone;
    logic [XLEN-1:0] dBuf;
    logic [XLEN-1:0] iBuf;

    logic            needD;
    logic            needI;
    logic            selData;
    logic            selFetch;
    logic            active;
    logic            expired;
    logic            abort;
    logic            cmpl;
    logic            dCmpl;
    logic            iCmpl;
    logic            timerClr;
    logic            timerEn;
    logic [XLEN-1:0] rdataEff;

    // Pick the requester, drive the bus and bypass completing read data.
    always_comb begin
        needD    = dm_req & ~dDone;
        needI    = if_req & ~iDone;
        selData  = reset & ((state == ST_DATA) |
                            ((state == ST_IDLE) & needD));
        selFetch = reset & ((state == ST_FETCH) |
                            ((state == ST_IDLE) & ~needD & needI));
        active   = selData | selFetch;
        abort    = reset & expired & ~bus.bus_ready &
                   (state != ST_IDLE);
        cmpl     = active & (bus.bus_ready | abort);
        dCmpl    = selData & cmpl;
        iCmpl    = selFetch & cmpl;
        rdataEff = bus.bus_ready ? bus.bus_rdata : '0;

        bus.bus_valid = active;
        bus.bus_we    = selData & dm_we;
        bus.bus_be    = selData ? dm_be : 4'hF;
        bus.bus_addr  = selData ? dm_addr : PCF;
        bus.bus_wdata = selData ? dm_wdata : '0;
        bus.bus_err   = abort;

        InstrF   = iCmpl ? rdataEff : iBuf;
        dm_rdata = dCmpl ? rdataEff : dBuf;

        mem_stall = (dm_req & ~(dDone | dCmpl)) |
                    (if_req & ~(iDone | iCmpl));

        timerClr = ~active | cmpl;
        timerEn  = active & ~bus.bus_ready;
    end

    mem_req_timer #(
        .LIMIT(TIMEOUT)
    ) uTimer (
        .clk    (clk),
        .reset  (reset),
        .clr    (timerClr),
        .en     (timerEn),
        .expired(expired)
    );

    // Bus FSM plus done flags and result buffers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            dDone <= 1'b0;
            iDone <= 1'b0;
            dBuf  <= '0;
            iBuf  <= '0;
        end else begin
            if (dCmpl && !dm_we) begin
                dBuf <= rdataEff;
            end
            if (iCmpl) begin
                iBuf <= rdataEff;
            end
            if (!mem_stall) begin
                dDone <= 1'b0;
                iDone <= 1'b0;
            end else begin
                if (dCmpl) begin
                    dDone <= 1'b1;
                end
                if (iCmpl) begin
                    iDone <= 1'b1;
                end
            end
            priority case (1'b1)
                cmpl:     state <= (selData & needI) ? ST_FETCH : ST_IDLE;
                selData:  state <= ST_DATA;
                selFetch: state <= ST_FETCH;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule
